// File: rtl/dnn_pkg.sv
// Shared fixed-point helpers and types for the DNN output-side blocks.
// Latency: n/a (combinational functions only).
// Backpressure: n/a.
package dnn_pkg;

    localparam int DNN_CNT_W = 32;

    typedef logic [DNN_CNT_W-1:0] dnn_cnt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mon_state_t;

    function automatic logic [63:0] dnn_one(input int fb);
        return 64'd1 << fb;
    endfunction

    // Clamp a sign-extended activation into the unit interval [0, ONE].
    function automatic logic [63:0] clamp_unit(input logic signed [63:0] v, input int fb);
        logic [63:0] one;
        one = dnn_one(fb);
        if (v[63])
            return 64'd0;
        else if ($unsigned(v) > one)
            return one;
        else
            return $unsigned(v);
    endfunction

endpackage

// File: rtl/dnn_output_monitor_window_tally.sv
// Sliding tally of correct cases over the last `window` finished cases.
// Latency: count updates on the edge after push.
// Backpressure: none; one push per cycle accepted, clr has priority.
module window_tally
    import dnn_pkg::*;
#(
    parameter int window = 100
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         bit_in,
    input  logic                         clr,
    output logic [$clog2(window+1)-1:0]  count
);

    localparam int PTR_W = $clog2(window);
    localparam int RC_W  = $clog2(window+1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(window - 1);

    logic [window-1:0] ring;
    logic [PTR_W-1:0]  wr_ptr;
    logic              evicted;

    assign evicted = ring[wr_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ring   <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            ring   <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            ring[wr_ptr] <= bit_in;
            // Unfilled slots hold 0, so early evictions subtract nothing.
            count  <= count + RC_W'(bit_in) - RC_W'(evicted);
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/dnn_output_monitor.sv
// Scores the one-neuron-per-clock DNN output stream: per-case verdict, L1 distance, lifetime and window stats.
// Latency: results and stats update on the edge sampling the last beat (cycle_index = cpc-1).
// Backpressure: none; the stream is consumed every cycle.
module dnn_output_monitor
    import dnn_pkg::*;
#(
    parameter int width     = 32,
    parameter int frac_bits = 21,
    parameter int cpc       = 18,
    parameter int n_out     = 16,
    parameter int window    = 100,
    parameter int cnt_w     = DNN_CNT_W
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [$clog2(cpc)-1:0]                 cycle_index,
    input  logic                                   a_out,
    input  logic                                   y_out,
    input  logic [width-1:0]                       actL,
    input  logic                                   stats_clr,
    output logic                                   case_valid,
    output logic                                   case_error,
    output logic [frac_bits+1+$clog2(n_out)-1:0]   case_l1,
    output logic [cnt_w-1:0]                       num_cases,
    output logic [cnt_w-1:0]                       total_error,
    output logic [$clog2(window+1)-1:0]            recent_correct
);

    localparam int CI_W = $clog2(cpc);
    localparam int L1_W = frac_bits + 1 + $clog2(n_out);
    localparam logic [CI_W-1:0] LAST_IDX  = CI_W'(cpc - 1);
    localparam logic [CI_W-1:0] FIRST_BEAT = CI_W'(2);
    localparam logic [63:0] ONE64 = dnn_one(frac_bits);

    mon_state_t state, state_nxt;

    logic              err_acc;
    logic [L1_W-1:0]   l1_acc;

    logic signed [63:0] act_sx;
    logic [63:0]        clamp_full;
    logic [63:0]        dist_full;
    logic [L1_W-1:0]    beat_dist;
    logic               unused_dist_hi;

    logic              beat;
    logic              fin;
    logic              err_now;
    logic [L1_W-1:0]   l1_now;

    assign act_sx     = {{(64-width){actL[width-1]}}, actL};
    assign clamp_full = clamp_unit(act_sx, frac_bits);
    assign dist_full  = y_out ? (ONE64 - clamp_full) : clamp_full;
    // Distance is bounded by ONE, so the low bits carry the whole value.
    assign beat_dist      = dist_full[L1_W-1:0];
    assign unused_dist_hi = ^dist_full[63:L1_W];

    assign beat    = (state == ST_RUN) && (cycle_index >= FIRST_BEAT);
    assign fin     = beat && (cycle_index == LAST_IDX);
    assign err_now = err_acc | (a_out ^ y_out);
    assign l1_now  = l1_acc + beat_dist;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cycle_index == '0) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_acc     <= 1'b0;
            l1_acc      <= '0;
            case_valid  <= 1'b0;
            case_error  <= 1'b0;
            case_l1     <= '0;
            num_cases   <= '0;
            total_error <= '0;
        end else begin
            case_valid <= fin;
            if (beat) begin
                if (fin) begin
                    err_acc <= 1'b0;
                    l1_acc  <= '0;
                end else begin
                    err_acc <= err_now;
                    l1_acc  <= l1_now;
                end
            end
            if (fin) begin
                case_error <= err_now;
                case_l1    <= l1_now;
            end
            // A coincident clear beats the finishing case for the statistics only.
            if (stats_clr) begin
                num_cases   <= '0;
                total_error <= '0;
            end else if (fin) begin
                num_cases   <= num_cases + cnt_w'(1);
                total_error <= total_error + cnt_w'(err_now);
            end
        end
    end

    window_tally #(
        .window (window)
    ) u_window_tally (
        .clk    (clk),
        .reset  (reset),
        .push   (fin),
        .bit_in (~err_now),
        .clr    (stats_clr),
        .count  (recent_correct)
    );

endmodule
